seq_datapath: RTL

SEQ_DATAPATH -- requirements
Module: seq_datapath

---
 rtl/seq_datapath_pkg.sv | 36 +++
 rtl/seq_datapath_if.sv | 38 +++
 rtl/seq_datapath_iter_muldiv.sv | 72 +++++++
 rtl/seq_datapath.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_datapath_pkg.sv
// Shared types for the sequential datapath: opcodes, FSM state encoding
// and a small opcode classification helper.
package seq_datapath_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHRA = 4'd5,
        OP_SHL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_NEG  = 4'd9,
        OP_NOT  = 4'd10,
        OP_MUL  = 4'd11,
        OP_DIV  = 4'd12,
        OP_MFHI = 4'd13,
        OP_MFLO = 4'd14,
        OP_ILL  = 4'd15
    } op_e;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_T1   = 3'd1;
    localparam state_t S_T2   = 3'd2;
    localparam state_t S_ITER = 3'd3;
    localparam state_t S_WB   = 3'd4;

    function automatic logic is_iter(op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_datapath_if.sv
// Request/register-port bundle of seq_datapath.
// master: drives start/op/ra/rb/rc, wr_*, rd_addr; slave: returns status, rd_data, hi, lo.
interface seq_datapath_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    localparam int AW = $clog2(NREGS);

    logic             start;
    logic [3:0]       op;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    rb;
    logic [AW-1:0]    rc;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             dbz;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, ra, rb, rc,
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, done, dbz, illegal, hi, lo
    );

    modport slave (
        input  start, op, ra, rb, rc,
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, done, dbz, illegal, hi, lo
    );

endinterface

// File: rtl/seq_datapath_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
// Ports: clk, rst_n, start, is_div, opa (multiplier/dividend), opb (multiplicand/divisor), done, hi, lo.
module iter_muldiv
    import seq_datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;
    logic             mode_div;
    logic             active;

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_sh;
    logic [WIDTH:0] div_diff;

    // {acc, qr} is the product register; the low half starts as the multiplier
    assign mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, m} : '0);
    // remainder shifted left with the next dividend bit, then trial subtract
    assign div_sh   = {acc, qr[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, m};

    // last step is taken on the same edge the FSM leaves ITER
    assign done = active && (cnt == CW'(1));
    assign hi   = acc;
    assign lo   = qr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            qr       <= '0;
            m        <= '0;
            cnt      <= '0;
            mode_div <= 1'b0;
            active   <= 1'b0;
        end else if (start) begin
            acc      <= '0;
            qr       <= opa;
            m        <= opb;
            cnt      <= CW'(WIDTH);
            mode_div <= is_div;
            active   <= 1'b1;
        end else if (active) begin
            if (mode_div) begin
                acc <= div_diff[WIDTH] ? div_sh[WIDTH-1:0]
                                       : div_diff[WIDTH-1:0];
                qr  <= {qr[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
                acc <= mul_sum[WIDTH:1];
                qr  <= {mul_sum[0], qr[WIDTH-1:1]};
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_datapath.sv
// Multi-cycle register-file datapath: IDLE -> T1 -> T2 -> (ITER) -> WB.
// Ports: Clock, Clear (async active-low), bus (slave: request, register load/read, status, HI/LO).
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input logic           Clock,
    input logic           Clear,
    seq_datapath_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW:0] WL = (SW+1)'(WIDTH);

    state_t           state;
    op_e              op_q;
    logic [AW-1:0]    ra_q;
    logic [AW-1:0]    rb_q;
    logic [AW-1:0]    rc_q;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z_hi;
    logic [WIDTH-1:0] z_lo;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;
    logic             dbz_r;
    logic             ill_r;
    logic [WIDTH-1:0] regs [NREGS];

    logic             busy;
    logic             accept;
    logic [WIDTH-1:0] rc_val;
    logic [SW-1:0]    sh;
    logic [SW:0]      inv_sh;
    logic             div0;
    logic             iter_op;
    logic             use_md;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] wb_hi;
    logic [WIDTH-1:0] wb_lo;
    logic             rf_we;
    logic [AW-1:0]    rf_addr;
    logic [WIDTH-1:0] rf_data;

    assign busy     = (state != S_IDLE);
    assign accept   = (state == S_IDLE) && bus.start;
    assign rc_val   = regs[rc_q];
    assign sh       = rc_val[SW-1:0];
    assign inv_sh   = WL - {1'b0, sh};
    assign div0     = (op_q == OP_DIV) && (rc_val == '0);
    assign iter_op  = is_iter(op_q);
    assign md_start = (state == S_T2) && iter_op && !div0;
    // divide-by-zero result was staged in Z, so it bypasses the iterator
    assign use_md   = iter_op && !dbz_r;
    assign wb_hi    = use_md ? md_hi : z_hi;
    assign wb_lo    = use_md ? md_lo : z_lo;

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (Clock),
        .rst_n  (Clear),
        .start  (md_start),
        .is_div (op_q == OP_DIV),
        .opa    (y),
        .opb    (rc_val),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_comb begin
        alu = '0;
        unique case (op_q)
            OP_ADD:  alu = y + rc_val;
            OP_SUB:  alu = y - rc_val;
            OP_AND:  alu = y & rc_val;
            OP_OR:   alu = y | rc_val;
            OP_SHR:  alu = y >> sh;
            OP_SHRA: alu = $signed(y) >>> sh;
            OP_SHL:  alu = y << sh;
            // shift by WIDTH yields 0, so sh == 0 rotates cleanly
            OP_ROR:  alu = (y >> sh) | (y << inv_sh);
            OP_ROL:  alu = (y << sh) | (y >> inv_sh);
            OP_NEG:  alu = '0 - y;
            OP_NOT:  alu = ~y;
            default: alu = '0;
        endcase
    end

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = ra_q;
        rf_data = wb_lo;
        unique case (1'b1)
            (state == S_WB): begin
                rf_we = (op_q != OP_ILL);
                if (op_q == OP_MFHI)
                    rf_data = hi_r;
                else if (op_q == OP_MFLO)
                    rf_data = lo_r;
            end
            (!busy && bus.wr_en): begin
                rf_we   = 1'b1;
                rf_addr = bus.wr_addr;
                rf_data = bus.wr_data;
            end
            default: ;
        endcase
    end

    // R0 is reset to zero and never written
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (rf_we && (rf_addr != '0)) begin
            regs[rf_addr] <= rf_data;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state  <= S_IDLE;
            op_q   <= OP_ADD;
            ra_q   <= '0;
            rb_q   <= '0;
            rc_q   <= '0;
            y      <= '0;
            z_hi   <= '0;
            z_lo   <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            ill_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= op_e'(bus.op);
                        ra_q  <= bus.ra;
                        rb_q  <= bus.rb;
                        rc_q  <= bus.rc;
                        dbz_r <= 1'b0;
                        ill_r <= 1'b0;
                        state <= S_T1;
                    end
                end
                S_T1: begin
                    y     <= regs[rb_q];
                    state <= S_T2;
                end
                S_T2: begin
                    if (div0) begin
                        z_hi  <= y;
                        z_lo  <= '1;
                        dbz_r <= 1'b1;
                        state <= S_WB;
                    end else if (iter_op) begin
                        state <= S_ITER;
                    end else begin
                        z_hi  <= '0;
                        z_lo  <= alu;
                        state <= S_WB;
                    end
                end
                S_ITER: begin
                    if (md_done)
                        state <= S_WB;
                end
                S_WB: begin
                    done_r <= 1'b1;
                    state  <= S_IDLE;
                    if (iter_op) begin
                        hi_r <= wb_hi;
                        lo_r <= wb_lo;
                    end
                    if (op_q == OP_ILL)
                        ill_r <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_data = regs[bus.rd_addr];
    assign bus.busy    = busy;
    assign bus.done    = done_r;
    assign bus.dbz     = dbz_r;
    assign bus.illegal = ill_r;
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;

endmodule
